// File: rtl/matrix_dma.sv
// Wishbone-fed loader/drainer for the Matrix_TOP accelerator: fetches A and B,
// kicks the multiply, polls status and writes C back to system memory.
module matrix_dma #(
   parameter int F_MATRIX_ROW_SIZE_MAX    = 3,
   parameter int F_MATRIX_COLUMN_SIZE_MAX = 3,
   parameter int S_MATRIX_COLUMN_SIZE_MAX = 3,
   parameter int POLL_TIMEOUT             = 4096
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [7:0]  i_rows,
   input  logic [7:0]  i_inner,
   input  logic [7:0]  i_cols,
   input  logic [31:0] i_a_base,
   input  logic [31:0] i_b_base,
   input  logic [31:0] i_c_base,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic [31:0] i_wb_rdt,
   input  logic        i_wb_ack,
   output logic [31:0] o_acc_data,
   output logic [10:0] o_acc_address,
   output logic        o_acc_we,
   input  logic [31:0] i_acc_rdt
);

   typedef enum logic [3:0] {
      IDLE, RD_A, WR_A, RD_B, WR_B, CTL_HI, CTL_LO,
      POLL_ADR, POLL_CHK, C_ADR, C_CAP, WR_C, FIN
   } state_t;

   localparam logic [7:0]  M_MAX      = F_MATRIX_ROW_SIZE_MAX[7:0];
   localparam logic [7:0]  K_MAX      = F_MATRIX_COLUMN_SIZE_MAX[7:0];
   localparam logic [7:0]  N_MAX      = S_MATRIX_COLUMN_SIZE_MAX[7:0];
   localparam logic [31:0] POLL_LIMIT = POLL_TIMEOUT[31:0];

   state_t      state;
   logic [7:0]  rows_q, inner_q, cols_q, idx;
   logic [31:0] a_base_q, b_base_q, c_base_q, poll_cnt;

   logic [15:0] cnt_a, cnt_b, cnt_c, idx_plus1;
   logic [7:0]  next_idx;
   logic [31:0] ctl_word;
   logic        size_bad, last_a, last_b, last_c;

   assign cnt_a     = {8'd0, rows_q}  * {8'd0, inner_q};
   assign cnt_b     = {8'd0, inner_q} * {8'd0, cols_q};
   assign cnt_c     = {8'd0, rows_q}  * {8'd0, cols_q};
   assign idx_plus1 = {8'd0, idx} + 16'd1;
   assign next_idx  = idx + 8'd1;
   assign last_a    = (idx_plus1 == cnt_a);
   assign last_b    = (idx_plus1 == cnt_b);
   assign last_c    = (idx_plus1 == cnt_c);
   assign ctl_word  = {8'd0, cols_q, inner_q, rows_q};
   assign size_bad  = (i_rows == 8'd0) || (i_inner == 8'd0) || (i_cols == 8'd0) ||
                      (i_rows > M_MAX) || (i_inner > K_MAX) || (i_cols > N_MAX);

   function automatic logic [31:0] elem_adr(input logic [31:0] base, input logic [7:0] i);
      return base + {22'd0, i, 2'b00};
   endfunction

   // All outputs are registered; each state sets up the outputs of the state it enters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         rows_q        <= '0;
         inner_q       <= '0;
         cols_q        <= '0;
         a_base_q      <= '0;
         b_base_q      <= '0;
         c_base_q      <= '0;
         idx           <= '0;
         poll_cnt      <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_err         <= 1'b0;
         o_wb_adr      <= '0;
         o_wb_dat      <= '0;
         o_wb_we       <= 1'b0;
         o_wb_cyc      <= 1'b0;
         o_acc_data    <= '0;
         o_acc_address <= '0;
         o_acc_we      <= 1'b0;
      end else begin
         o_done   <= 1'b0;
         o_err    <= 1'b0;
         o_acc_we <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  rows_q   <= i_rows;
                  inner_q  <= i_inner;
                  cols_q   <= i_cols;
                  a_base_q <= i_a_base;
                  b_base_q <= i_b_base;
                  c_base_q <= i_c_base;
                  idx      <= '0;
                  poll_cnt <= '0;
                  if (size_bad) begin
                     o_err <= 1'b1;
                  end else begin
                     o_busy   <= 1'b1;
                     o_wb_cyc <= 1'b1;
                     o_wb_we  <= 1'b0;
                     o_wb_adr <= i_a_base;
                     state    <= RD_A;
                  end
               end
            end
            RD_A, RD_B: begin
               if (i_wb_ack) begin
                  o_wb_cyc      <= 1'b0;
                  o_acc_we      <= 1'b1;
                  o_acc_address <= {(state == RD_A) ? 3'd1 : 3'd2, idx};
                  o_acc_data    <= i_wb_rdt;
                  state         <= (state == RD_A) ? WR_A : WR_B;
               end
            end
            WR_A: begin
               o_wb_cyc <= 1'b1;
               if (last_a) begin
                  idx      <= '0;
                  o_wb_adr <= b_base_q;
                  state    <= RD_B;
               end else begin
                  idx      <= next_idx;
                  o_wb_adr <= elem_adr(a_base_q, next_idx);
                  state    <= RD_A;
               end
            end
            WR_B: begin
               if (last_b) begin
                  idx           <= '0;
                  o_acc_we      <= 1'b1;
                  o_acc_address <= '0;
                  o_acc_data    <= ctl_word | 32'h0100_0000;
                  state         <= CTL_HI;
               end else begin
                  idx      <= next_idx;
                  o_wb_cyc <= 1'b1;
                  o_wb_adr <= elem_adr(b_base_q, next_idx);
                  state    <= RD_B;
               end
            end
            CTL_HI: begin
               o_acc_we   <= 1'b1;
               o_acc_data <= ctl_word;
               state      <= CTL_LO;
            end
            CTL_LO: begin
               o_acc_address <= {3'd4, 8'd0};
               state         <= POLL_ADR;
            end
            POLL_ADR: state <= POLL_CHK;
            // Status data arrives one cycle after the bank-4 address went out.
            POLL_CHK: begin
               if (i_acc_rdt == 32'd1) begin
                  o_acc_address <= {3'd3, idx};
                  state         <= C_ADR;
               end else if (poll_cnt + 32'd1 == POLL_LIMIT) begin
                  o_err  <= 1'b1;
                  o_busy <= 1'b0;
                  state  <= IDLE;
               end else begin
                  poll_cnt <= poll_cnt + 32'd1;
                  state    <= POLL_ADR;
               end
            end
            C_ADR: state <= C_CAP;
            C_CAP: begin
               o_wb_cyc <= 1'b1;
               o_wb_we  <= 1'b1;
               o_wb_adr <= elem_adr(c_base_q, idx);
               o_wb_dat <= i_acc_rdt;
               state    <= WR_C;
            end
            WR_C: begin
               if (i_wb_ack) begin
                  o_wb_cyc <= 1'b0;
                  o_wb_we  <= 1'b0;
                  if (last_c) begin
                     state <= FIN;
                  end else begin
                     idx           <= next_idx;
                     o_acc_address <= {3'd3, next_idx};
                     state         <= C_ADR;
                  end
               end
            end
            FIN: begin
               o_done <= 1'b1;
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/matrix_dma.md
Name: matrix_dma

Overview:
- Upstream feeder and result drain for the Matrix_TOP matrix-multiply accelerator.
- On a start pulse it fetches operand matrices A and B from system memory over a Wishbone classic master port and writes them into the accelerator's address-mapped banks.
- It then issues the start sequence, polls the status bank until the multiply is done, and writes result matrix C back to memory.
- It lets the SERV core offload a full multiply with one command.

Parameters:
- F_MATRIX_ROW_SIZE_MAX, 3, max rows of A (must match Matrix_TOP)
- F_MATRIX_COLUMN_SIZE_MAX, 3, max columns of A = rows of B
- S_MATRIX_COLUMN_SIZE_MAX, 3, max columns of B
- POLL_TIMEOUT, 4096, max cycles spent polling status before error

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle command pulse; ignored while o_busy=1
- i_rows  in  8  rows of A (m)
- i_inner  in  8  columns of A / rows of B (k)
- i_cols  in  8  columns of B (n)
- i_a_base, i_b_base, i_c_base  in  32 each  byte addresses, word aligned, row-major 32-bit elements
- o_busy  out  1  high from accepted start until done/err
- o_done  out  1  one-cycle pulse on successful completion
- o_err  out  1  one-cycle pulse on bad size or poll timeout
- o_wb_adr  out  32  Wishbone byte address
- o_wb_dat  out  32  write data
- o_wb_we  out  1  write enable
- o_wb_cyc  out  1  cycle/strobe (combined)
- i_wb_rdt  in  32  read data
- i_wb_ack  in  1  acknowledge
- o_acc_data  out  32  to Matrix_TOP data
- o_acc_address  out  11  to Matrix_TOP address; [10:8] bank, [7:0] element index
- o_acc_we  out  1  to Matrix_TOP we
- i_acc_rdt  in  32  from Matrix_TOP o_data_rdt

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters 0. Reset is asynchronous at any point and abandons any transfer, including a mid-Wishbone cycle; o_wb_cyc drops immediately.
- Accelerator banks:
  - 0 = control: data[7:0]=m, [15:8]=k, [23:16]=n, [24]=start
  - 1 = A, 2 = B, 3 = C (read), 4 = status; status reads 1 when done
- Accelerator read latency: i_acc_rdt is valid 1 cycle after o_acc_address is presented.
- Accelerator write: o_acc_we is high for exactly 1 cycle, with address and data stable in that cycle.
- Start accept: in IDLE, i_start latches all size and base inputs.
  - If any size is 0, or m>F_MATRIX_ROW_SIZE_MAX, k>F_MATRIX_COLUMN_SIZE_MAX or n>S_MATRIX_COLUMN_SIZE_MAX: pulse o_err next cycle, stay IDLE, no bus activity.
- FSM states: IDLE -> RD_A -> WR_A (repeat m*k) -> RD_B -> WR_B (repeat k*n) -> CTL_HI -> CTL_LO -> POLL_ADR -> POLL_CHK -> C_ADR -> C_CAP -> WR_C (repeat m*n) -> FIN -> IDLE.
- RD_x:
  - Assert o_wb_cyc=1, o_wb_we=0, o_wb_adr=base+4*idx, and hold them until i_wb_ack.
  - On ack, capture i_wb_rdt, deassert cyc in the same edge, go to WR_x.
  - Wait states are unbounded.
- WR_x: o_acc_address={bank,idx[7:0]}, o_acc_data=captured word, o_acc_we=1 for one cycle. Then increment idx, or clear idx and advance to the next phase when idx=count-1.
- CTL_HI: writes control word with bit24=1. CTL_LO writes the same word with bit24=0. These are 2 consecutive we cycles at address 0.
- POLL_ADR: present bank 4. POLL_CHK, one cycle later:
  - i_acc_rdt==1: go to C_ADR.
  - Otherwise return to POLL_ADR and increment the timeout counter.
  - Counter reaching POLL_TIMEOUT: pulse o_err and go IDLE.
- C_ADR presents {3'd3,idx}. C_CAP latches i_acc_rdt. WR_C performs a Wishbone write of the latched word to c_base+4*idx with cyc/we held until ack.
- FIN: pulse o_done and drop o_busy on the same edge.
- o_busy=1 in every state except IDLE.
- Address arithmetic: 32-bit, wraps modulo 2^32 silently. Index width is 8 bits; m*k, k*n and m*n are all ≤255 under the size checks.
- i_start while busy: ignored, and latched values are unaffected.
- o_done and o_err never assert in the same cycle.

Test Plan:
- Reset: hold i_rst_n=0, then release. All outputs are 0. A start with m=k=n=3, a_base=0x100, b_base=0x200, c_base=0x300, memory A[i]=i, B[i]=i, behind a zero-wait ack memory with Matrix_TOP attached:
  - 9 writes to bank1, 9 to bank2, then control 0x01030303 followed by 0x00030303.
  - Memory at 0x300..0x320 = {15,18,21,42,54,66,69,90,111}.
  - One o_done pulse; o_busy low afterwards.
- Random 0-5 cycle ack delays on every Wishbone access: identical C result. o_wb_adr and o_wb_cyc are stable throughout each stall.
- i_rows=0, or i_cols=4 with max 3: o_err pulses 1 cycle after start; o_wb_cyc and o_acc_we stay 0; o_busy stays 0.
- Status model never returns 1 with POLL_TIMEOUT=16: o_err pulses after 16 polls, no C writes occur, and the FSM returns to IDLE.
- Assert i_rst_n=0 during the B load, mid-Wishbone stall: o_wb_cyc drops asynchronously. A following start runs a full correct transfer.
- Pulse i_start again during the poll phase with different bases: it is ignored, and results land at the original c_base.
